// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the memory port arbiter
//
// Purpose: FSM state encoding and requester/owner identifiers used by
//          mem_port_arbiter and arb_prio_sel.
// Ports:   none (package).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // OWN_NONE marks "no transaction in flight"; it is also the reset owner.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

endpackage

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - combinational 3-way priority pick with fetch promotion
//
// Purpose: picks one winner among fetch, load/store and debug requests.
//          Normal order DBG > LS > IF; with promote_i the order is IF > DBG > LS.
// Ports:   if_req_i, ls_req_i, dbg_req_i  requests (if_req_i already qualified)
//          promote_i                       fetch has starved long enough
//          win_o                           winning owner, OWN_NONE if no request
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req_i,
  input  logic   ls_req_i,
  input  logic   dbg_req_i,
  input  logic   promote_i,
  output owner_e win_o
);

  always_comb begin
    win_o = OWN_NONE;
    if (promote_i && if_req_i) begin
      win_o = OWN_IF;
    end else if (dbg_req_i) begin
      win_o = OWN_DBG;
    end else if (ls_req_i) begin
      win_o = OWN_LS;
    end else if (if_req_i) begin
      win_o = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch, load/store and debug
//
// Purpose: serialises IF/LS/DBG accesses onto one memory port, one transaction
//          at a time (IDLE -> WAIT -> RESP), stalls fetch while it is blocked and
//          drops in-flight fetch responses on a pipeline redirect.
// Ports:   clk, rst                       clock, synchronous active-high reset
//          if_*   fetch read port         req/addr in, gnt/rvalid/rdata out
//          ls_*   load/store port         req/we/addr/wdata/be in, gnt/rvalid/rdata out
//          dbg_*  debug port              req/we/addr/wdata in, gnt/rvalid/rdata out
//          jump_en_i                      redirect; flushes the in-flight fetch
//          mem_*  memory command/response req/we/addr/wdata/be out, rdata in
//          hold_flag_o                    fetch stall (if_req_i & ~if_gnt_o)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  input  logic [DW/8-1:0] ls_be_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [DW-1:0]   ls_rdata_o,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic [DW-1:0]   dbg_wdata_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [DW-1:0]   dbg_rdata_o,
  input  logic            jump_en_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            hold_flag_o
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
  logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic [DW-1:0]   rsp_data;
  logic            if_eligible;
  logic            promote;
  logic            if_flushed;
  owner_e          win;

  // A fetch address presented together with a redirect is stale: never grant it.
  assign if_eligible = if_req_i & ~jump_en_i;
  assign promote     = (starve_q == SW'(STARVE_MAX));
  // A fetch is dead once a redirect has been seen at any point after issue.
  assign if_flushed  = drop_q | jump_en_i;

  arb_prio_sel u_prio_sel (
    .if_req_i  (if_eligible),
    .ls_req_i  (ls_req_i),
    .dbg_req_i (dbg_req_i),
    .promote_i (promote),
    .win_o     (win)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    drop_d       = drop_q;
    wait_cnt_d   = wait_cnt_q;
    starve_d     = starve_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    if_gnt_o     = 1'b0;
    ls_gnt_o     = 1'b0;
    dbg_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    ls_rvalid_o  = 1'b0;
    dbg_rvalid_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    // Writes acknowledge with zero data.
    rsp_data     = we_q ? '0 : mem_rdata_i;

    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
          owner_d = OWN_NONE;
          drop_d  = 1'b0;
          if (win == OWN_IF) begin
            starve_d = '0;
          end else if (if_eligible && !promote) begin
            starve_d = starve_q + SW'(1);
          end
          if (win != OWN_NONE) begin
            mem_req_o  = 1'b1;
            owner_d    = win;
            wait_cnt_d = CW'(RD_LAT - 1);
            state_d    = ARB_WAIT;
            unique case (win)
              OWN_IF: begin
                if_gnt_o   = 1'b1;
                mem_addr_o = if_addr_i;
                mem_be_o   = '1;
              end
              OWN_LS: begin
                ls_gnt_o    = 1'b1;
                mem_we_o    = ls_we_i;
                mem_addr_o  = ls_addr_i;
                mem_wdata_o = ls_wdata_i;
                mem_be_o    = ls_be_i;
              end
              OWN_DBG: begin
                dbg_gnt_o   = 1'b1;
                mem_we_o    = dbg_we_i;
                mem_addr_o  = dbg_addr_i;
                mem_wdata_o = dbg_wdata_i;
                mem_be_o    = '1;
              end
              default: ;
            endcase
            we_d = mem_we_o;
          end
        end
        ARB_WAIT: begin
          if (owner_q == OWN_IF && jump_en_i) begin
            drop_d = 1'b1;
          end
          if (wait_cnt_q == '0) begin
            state_d = ARB_RESP;
            unique case (owner_q)
              OWN_IF:  if (!if_flushed) if_rdata_d = rsp_data;
              OWN_LS:  ls_rdata_d  = rsp_data;
              OWN_DBG: dbg_rdata_d = rsp_data;
              default: ;
            endcase
          end else begin
            wait_cnt_d = wait_cnt_q - CW'(1);
          end
        end
        ARB_RESP: begin
          state_d = ARB_IDLE;
          unique case (owner_q)
            OWN_IF:  if_rvalid_o  = ~if_flushed;
            OWN_LS:  ls_rvalid_o  = 1'b1;
            OWN_DBG: dbg_rvalid_o = 1'b1;
            default: ;
          endcase
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      drop_q      <= 1'b0;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      drop_q      <= drop_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign hold_flag_o = ~rst & if_req_i & ~if_gnt_o;
  assign if_rdata_o  = rst ? '0 : if_rdata_q;
  assign ls_rdata_o  = rst ? '0 : ls_rdata_q;
  assign dbg_rdata_o = rst ? '0 : dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic [3:0]  ls_be_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
  logic        dbg_gnt_o, dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        jump_en_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;
  logic        hold_flag_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .jump_en_i(jump_en_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Memory model: unwritten words read back as a pattern derived from the address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_req_o && mem_we_o) begin
      mem[mem_addr_o] = merge(mem_rd(mem_addr_o), mem_wdata_o, mem_be_o);
      mem_rdata_i <= 32'hBAD0_BAD0;
    end else if (mem_req_o) begin
      mem_rdata_i <= mem_rd(mem_addr_o);
    end else begin
      mem_rdata_i <= 32'hBAD0_BAD0;
    end
  end

  // Scoreboard: one entry per issued transaction, consumed in its RESP cycle.
  typedef struct {
    int          id;
    logic [31:0] data;
    bit          drop;
  } exp_t;

  exp_t sb[$];
  int   m_busy   = 0;
  int   m_starve = 0;

  always @(negedge clk) begin
    logic [2:0]  rv;
    logic [2:0]  gv;
    int          w;
    bit          ifr;
    exp_t        e;
    logic [68:0] cmd;
    rv = {dbg_rvalid_o, ls_rvalid_o, if_rvalid_o};
    gv = {dbg_gnt_o, ls_gnt_o, if_gnt_o};
    if (rst) begin
      chk("rst_outs", {gv, rv, mem_req_o, mem_we_o, hold_flag_o, |mem_addr_o,
                       |mem_wdata_o, |mem_be_o, |if_rdata_o, |ls_rdata_o, |dbg_rdata_o}, '0);
      sb.delete();
      m_busy   = 0;
      m_starve = 0;
    end else if (m_busy > 0) begin
      if (sb.size() > 0 && sb[0].id == 1 && jump_en_i) sb[0].drop = 1'b1;
      chk("busy_gnt", {gv, mem_req_o}, '0);
      chk("busy_hold", hold_flag_o, if_req_i);
      if (m_busy == 1) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_rv", rv, e.drop ? 3'b000 : 3'(1 << (e.id - 1)));
          if (!e.drop) begin
            case (e.id)
              1:       chk("resp_if_data", if_rdata_o, e.data);
              2:       chk("resp_ls_data", ls_rdata_o, e.data);
              default: chk("resp_dbg_data", dbg_rdata_o, e.data);
            endcase
          end
        end
      end else begin
        chk("wait_rv", rv, 3'b000);
      end
      m_busy--;
    end else begin
      chk("idle_rv", rv, 3'b000);
      ifr = if_req_i && !jump_en_i;
      if (ifr && m_starve == STARVE_MAX) w = 1;
      else if (dbg_req_i) w = 3;
      else if (ls_req_i) w = 2;
      else if (ifr) w = 1;
      else w = 0;
      chk("gnt", gv, (w == 0) ? 3'b000 : 3'(1 << (w - 1)));
      chk("hold", hold_flag_o, if_req_i && (w != 1));
      chk("mem_req", mem_req_o, w != 0);
      case (w)
        1:       cmd = {1'b0, if_addr_i, 32'h0, 4'hF};
        2:       cmd = {ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i};
        3:       cmd = {dbg_we_i, dbg_addr_i, dbg_wdata_i, 4'hF};
        default: cmd = '0;
      endcase
      chk("mem_cmd", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, cmd);
      if (w != 0) begin
        e.id   = w;
        e.drop = 1'b0;
        e.data = cmd[68] ? 32'h0 : mem_rd(cmd[67:36]);
        sb.push_back(e);
        m_busy = RD_LAT + 1;
      end
      if (w == 1) m_starve = 0;
      else if (ifr && m_starve < STARVE_MAX) m_starve++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request, hold it until granted, then let the transaction finish.
  task automatic do_req(input int id, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    bit got = 1'b0;
    case (id)
      1: begin if_req_i = 1'b1; if_addr_i = a; end
      2: begin ls_req_i = 1'b1; ls_we_i = we; ls_addr_i = a; ls_wdata_i = wd; ls_be_i = be; end
      default: begin dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = wd; end
    endcase
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (id == 1) ? if_gnt_o : (id == 2) ? ls_gnt_o : dbg_gnt_o;
      @(posedge clk);
      #1;
    end
    if_req_i = 1'b0; ls_req_i = 1'b0; dbg_req_i = 1'b0;
    if (!got) chk("req_timeout", 0, 1);
    idle(RD_LAT + 1);
  endtask

  initial begin
    int n;
    bit got;
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  denied;
    bit  got;
    mem[32'h100]  = 32'h0000_0013;
    mem[32'h3000] = 32'h1122_3344;
    idle(3);
    rst = 1'b0;
    idle(2);

    // 1: single fetch
    do_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
    chk("t1_rdata", if_rdata_o, 32'h13);

    // 2: fetch and load together; load wins, fetch follows on next IDLE
    if_req_i = 1'b1; if_addr_i = 32'h104;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h2000;
    @(negedge clk);
    chk("t2_ls_first", {ls_gnt_o, if_gnt_o}, 2'b10);
    @(posedge clk); #1;
    ls_req_i = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      n++;
      @(negedge clk);
      got = if_gnt_o;
      @(posedge clk); #1;
    end
    if_req_i = 1'b0;
    chk("t2_if_gap", n, RD_LAT + 2);
    idle(RD_LAT + 1);
    chk("t2_ls_rdata", ls_rdata_o, 32'h5A5A_2000);

    // 3: continuous LS+DBG traffic starves fetch until promotion
    if_req_i = 1'b1; if_addr_i = 32'h108;
    ls_req_i = 1'b1; ls_addr_i = 32'h2004;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h600;
    got = 1'b0;
    denied = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = if_gnt_o;
      if (!got && (ls_gnt_o || dbg_gnt_o)) denied++;
      @(posedge clk); #1;
    end
    if_req_i = 1'b0; ls_req_i = 1'b0; dbg_req_i = 1'b0;
    chk("t3_granted", got, 1'b1);
    chk("t3_denied", denied, STARVE_MAX);
    idle(RD_LAT + 1);
    // counter cleared: a fresh IF+LS pair goes to LS again
    if_req_i = 1'b1; if_addr_i = 32'h10C;
    ls_req_i = 1'b1; ls_addr_i = 32'h2008;
    @(negedge clk);
    chk("t3_cleared", {ls_gnt_o, if_gnt_o}, 2'b10);
    @(posedge clk); #1;
    ls_req_i = 1'b0;
    idle(RD_LAT + 1);
    do_req(1, 1'b0, 32'h10C, 32'h0, 4'h0);
    chk("t3_if_rdata", if_rdata_o, 32'h5A5A_010C);

    // 4: redirect during WAIT kills the fetch response, next fetch is normal
    if_req_i = 1'b1; if_addr_i = 32'h200;
    @(negedge clk);
    chk("t4_gnt", if_gnt_o, 1'b1);
    @(posedge clk); #1;
    if_req_i = 1'b0;
    jump_en_i = 1'b1;
    @(posedge clk); #1;
    jump_en_i = 1'b0;
    idle(RD_LAT + 1);
    chk("t4_rdata_held", if_rdata_o, 32'h5A5A_010C);
    do_req(1, 1'b0, 32'h400, 32'h0, 4'h0);
    chk("t4_next_rdata", if_rdata_o, 32'h5A5A_0400);
    // redirect while a load is in flight is ignored
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h2010;
    @(negedge clk);
    @(posedge clk); #1;
    ls_req_i = 1'b0;
    jump_en_i = 1'b1;
    @(posedge clk); #1;
    jump_en_i = 1'b0;
    idle(RD_LAT + 1);
    chk("t4_ls_rdata", ls_rdata_o, 32'h5A5A_2010);
    // fetch with a redirect in the same cycle is not granted
    if_req_i = 1'b1; if_addr_i = 32'h404; jump_en_i = 1'b1;
    @(negedge clk);
    chk("t4_jump_block", {if_gnt_o, hold_flag_o}, 2'b01);
    @(posedge clk); #1;
    if_req_i = 1'b0; jump_en_i = 1'b0;

    // 5: partial write, ack with zero data, then read back the merge
    do_req(2, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011);
    chk("t5_wr_rdata", ls_rdata_o, 32'h0);
    do_req(2, 1'b0, 32'h3000, 32'h0, 4'hF);
    chk("t5_rd_merge", ls_rdata_o, 32'h1122_BEEF);
    do_req(3, 1'b1, 32'h3004, 32'hCAFE_F00D, 4'h0);
    do_req(3, 1'b0, 32'h3004, 32'h0, 4'h0);
    chk("t5_dbg_rd", dbg_rdata_o, 32'hCAFE_F00D);

    // 6: reset in the middle of a debug read
    do_req(3, 1'b0, 32'h700, 32'h0, 4'h0);
    chk("t6_pre", dbg_rdata_o, 32'h5A5A_0700);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h704;
    @(negedge clk);
    chk("t6_gnt", dbg_gnt_o, 1'b1);
    @(posedge clk); #1;
    dbg_req_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after", {dbg_rvalid_o, dbg_gnt_o, mem_req_o, hold_flag_o, dbg_rdata_o,
                     ls_rdata_o, if_rdata_o}, '0);
    idle(4);
    chk("t6_dbg_rdata", dbg_rdata_o, 32'h0);
    do_req(3, 1'b0, 32'h708, 32'h0, 4'h0);
    chk("t6_recover", dbg_rdata_o, 32'h5A5A_0708);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
